// File: rtl/esc_seq_pkg.sv
// Shared types and defaults for the ESC sequencer: state encoding, speed width and speed helpers.
package esc_seq_pkg;

    localparam int SPD_W = 11;

    localparam logic [SPD_W-1:0] MIN_SPD_DEF   = 11'd64;
    localparam logic [SPD_W-1:0] SLEW_STEP_DEF = 11'd32;
    localparam logic [SPD_W-1:0] SPD_MAX       = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } esc_state_e;

    function automatic logic [SPD_W-1:0] spd_max(input logic [SPD_W-1:0] a,
                                                 input logic [SPD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/esc_slew_lim.sv
// Per-motor slew limiter: moves cur toward target by at most step, saturating to 0..2047.
module esc_slew_lim
    import esc_seq_pkg::*;
(
    input  logic [SPD_W-1:0] cur,
    input  logic [SPD_W-1:0] target,
    input  logic [SPD_W-1:0] step,
    output logic [SPD_W-1:0] next
);

    logic signed [SPD_W:0] diff;
    logic signed [SPD_W:0] step_s;
    logic        [SPD_W:0] up_sum;

    always_comb begin
        diff   = $signed({1'b0, target}) - $signed({1'b0, cur});
        step_s = $signed({1'b0, step});
        up_sum = {1'b0, cur} + {1'b0, step};
        if (diff > step_s) begin
            next = up_sum[SPD_W] ? SPD_MAX : up_sum[SPD_W-1:0];
        end else if (diff < -step_s) begin
            next = (cur > step) ? (cur - step) : '0;
        end else begin
            next = target;
        end
    end

endmodule

// File: rtl/esc_sequencer.sv
// ESC arming/kill sequencer with frame-aligned, slew-limited speed outputs.
// Optional command watchdog enabled by defining ESC_SEQ_CMD_WDOG_EN.
//
// state     | meaning
// ST_IDLE   | outputs 0, waiting for arm_req
// ST_ARMING | MIN_SPD held for ARM_FRAMES frames
// ST_RUN    | outputs slew toward max(shadow, MIN_SPD) once per frame
// ST_FAULT  | outputs 0; leaves only with kill and arm_req both low
module esc_sequencer
    import esc_seq_pkg::*;
#(
    parameter int               FRAME_W     = 20,
    parameter int               ARM_FRAMES  = 16,
    parameter logic [SPD_W-1:0] MIN_SPD     = MIN_SPD_DEF,
    parameter logic [SPD_W-1:0] SLEW_STEP   = SLEW_STEP_DEF,
    parameter int               WDOG_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_req,
    input  logic             kill,
    input  logic             cmd_vld,
    input  logic [SPD_W-1:0] frnt_cmd,
    input  logic [SPD_W-1:0] bck_cmd,
    input  logic [SPD_W-1:0] lft_cmd,
    input  logic [SPD_W-1:0] rght_cmd,
    output logic [SPD_W-1:0] frnt_spd,
    output logic [SPD_W-1:0] bck_spd,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             frame_tick,
    output logic             armed,
    output logic             fault
);

    localparam int ARM_W = $clog2(ARM_FRAMES + 1);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    esc_state_e         state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [SPD_W-1:0]   shadow_q [4];
    logic [SPD_W-1:0]   shadow_d [4];
    logic [SPD_W-1:0]   spd_q    [4];
    logic [SPD_W-1:0]   spd_d    [4];
    logic [SPD_W-1:0]   cmd_in   [4];
    logic [SPD_W-1:0]   tgt      [4];
    logic [SPD_W-1:0]   slew_nxt [4];
    logic               wdog_exp;
    logic               zero_all, load_min, load_slew;

    assign frame_cnt_d = frame_cnt_q + 1'b1;
    assign frame_tick  = &frame_cnt_q;

    // A command arriving on the tick cycle feeds that tick's update directly.
    always_comb begin
        cmd_in[0] = frnt_cmd;
        cmd_in[1] = bck_cmd;
        cmd_in[2] = lft_cmd;
        cmd_in[3] = rght_cmd;
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = cmd_vld ? cmd_in[i] : shadow_q[i];
            tgt[i]      = spd_max(shadow_d[i], MIN_SPD);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_slew
        esc_slew_lim u_slew (
            .cur    (spd_q[g]),
            .target (tgt[g]),
            .step   (SLEW_STEP),
            .next   (slew_nxt[g])
        );
    end

`ifdef ESC_SEQ_CMD_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_FRAMES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Held at zero outside RUN so every entry to RUN starts a fresh count.
    always_comb begin
        wdog_d   = wdog_q;
        wdog_exp = 1'b0;
        if (state_q != ST_RUN || cmd_vld) begin
            wdog_d = '0;
        end else if (frame_tick) begin
            wdog_d   = wdog_q + 1'b1;
            wdog_exp = (wdog_d == WDOG_W'(WDOG_FRAMES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^WDOG_FRAMES;
    assign wdog_exp        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        zero_all  = 1'b0;
        load_min  = 1'b0;
        load_slew = 1'b0;
        if (kill) begin
            state_d  = ST_FAULT;
            zero_all = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    zero_all = 1'b1;
                    if (arm_req) begin
                        state_d   = ST_ARMING;
                        arm_cnt_d = '0;
                    end
                end
                ST_ARMING: begin
                    if (!arm_req) begin
                        state_d  = ST_IDLE;
                        zero_all = 1'b1;
                    end else if (frame_tick) begin
                        load_min  = 1'b1;
                        arm_cnt_d = arm_cnt_q + 1'b1;
                        if (arm_cnt_q == ARM_W'(ARM_FRAMES - 1)) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!arm_req) begin
                        state_d  = ST_IDLE;
                        zero_all = 1'b1;
                    end else if (wdog_exp) begin
                        state_d  = ST_FAULT;
                        zero_all = 1'b1;
                    end else if (frame_tick) begin
                        load_slew = 1'b1;
                    end
                end
                ST_FAULT: begin
                    zero_all = 1'b1;
                    if (!arm_req) state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    zero_all = 1'b1;
                end
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            spd_d[i] = spd_q[i];
            if (zero_all)       spd_d[i] = '0;
            else if (load_min)  spd_d[i] = MIN_SPD;
            else if (load_slew) spd_d[i] = slew_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            state_q     <= ST_IDLE;
            arm_cnt_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                spd_q[i]    <= '0;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                spd_q[i]    <= spd_d[i];
            end
        end
    end

    assign frnt_spd = spd_q[0];
    assign bck_spd  = spd_q[1];
    assign lft_spd  = spd_q[2];
    assign rght_spd = spd_q[3];
    assign armed    = (state_q == ST_RUN);
    assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_esc_sequencer.sv
// Bench for esc_sequencer: directed scenarios plus random traffic against a frame-level model.
module tb_esc_sequencer;

    localparam int FW    = 6;
    localparam int AF    = 4;
    localparam int WF    = 3;
    localparam int MINS  = 64;
    localparam int STEP  = 32;
    localparam int FLEN  = 1 << FW;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm_req, kill, cmd_vld;
    logic [10:0] cmd [4];
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        frame_tick, armed, fault;

    esc_sequencer #(
        .FRAME_W     (FW),
        .ARM_FRAMES  (AF),
        .MIN_SPD     (11'(MINS)),
        .SLEW_STEP   (11'(STEP)),
        .WDOG_FRAMES (WF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm_req    (arm_req),
        .kill       (kill),
        .cmd_vld    (cmd_vld),
        .frnt_cmd   (cmd[0]),
        .bck_cmd    (cmd[1]),
        .lft_cmd    (cmd[2]),
        .rght_cmd   (cmd[3]),
        .frnt_spd   (frnt_spd),
        .bck_spd    (bck_spd),
        .lft_spd    (lft_spd),
        .rght_spd   (rght_spd),
        .frame_tick (frame_tick),
        .armed      (armed),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame position, mode, frames spent arming, frames since last command.
    int m_cnt, m_mode, m_arms, m_wd;
    int m_sh  [4];
    int m_spd [4];

    function automatic int approach(input int c, input int t);
        int d;
        d = t - c;
        if (d > STEP)       return (c + STEP > 2047) ? 2047 : c + STEP;
        else if (d < -STEP) return (c - STEP < 0) ? 0 : c - STEP;
        else                return t;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 4; i++) m_spd[i] = 0;
    endtask

    task automatic model_edge();
        bit tk;
        bit bite;
        tk   = (m_cnt == FLEN - 1);
        bite = 1'b0;
        if (cmd_vld) for (int i = 0; i < 4; i++) m_sh[i] = int'(cmd[i]);
        if (kill) begin
            m_mode = M_FAULT;
            model_zero();
        end else begin
            case (m_mode)
                M_IDLE: if (arm_req) begin m_mode = M_ARM; m_arms = 0; end
                M_ARM: begin
                    if (!arm_req) begin
                        m_mode = M_IDLE; model_zero();
                    end else if (tk) begin
                        for (int i = 0; i < 4; i++) m_spd[i] = MINS;
                        m_arms++;
                        if (m_arms == AF) begin m_mode = M_RUN; m_wd = 0; end
                    end
                end
                M_RUN: begin
                    if (!arm_req) begin
                        m_mode = M_IDLE; model_zero();
                    end else begin
`ifdef ESC_SEQ_CMD_WDOG_EN
                        if (cmd_vld) m_wd = 0;
                        else if (tk) begin m_wd++; bite = (m_wd >= WF); end
`endif
                        if (bite) begin
                            m_mode = M_FAULT; model_zero();
                        end else if (tk) begin
                            for (int i = 0; i < 4; i++)
                                m_spd[i] = approach(m_spd[i], (m_sh[i] > MINS) ? m_sh[i] : MINS);
                        end
                    end
                end
                default: if (!arm_req) m_mode = M_IDLE;
            endcase
        end
        m_cnt = (m_cnt + 1) % FLEN;
    endtask

    function automatic logic [43:0] spd_all();
        return {frnt_spd, bck_spd, lft_spd, rght_spd};
    endfunction

    function automatic logic [43:0] model_all();
        logic [43:0] e;
        e = {11'(m_spd[0]), 11'(m_spd[1]), 11'(m_spd[2]), 11'(m_spd[3])};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick",  frame_tick, (m_cnt == FLEN - 1));
        chk("armed", armed, (m_mode == M_RUN));
        chk("fault", fault, (m_mode == M_FAULT));
        chk("spd",   spd_all(), model_all());
    endtask

    task automatic set_cmd(input int v);
        for (int i = 0; i < 4; i++) cmd[i] = 11'(v);
    endtask

    // Re-sends the current command once per 64 cycles so a watchdog build stays in RUN.
    task automatic run_frames(input int n);
        repeat (n) begin
            cmd_vld = 1'b1;
            step();
            cmd_vld = 1'b0;
            repeat (FLEN - 1) step();
        end
    endtask

    function automatic logic [10:0] rand_cmd();
        case ($urandom_range(0, 3))
            0:       return 11'd0;
            1:       return 11'd2047;
            2:       return 11'($urandom_range(0, 2047));
            default: return 11'($urandom_range(0, 100));
        endcase
    endfunction

    initial begin
        rst_n   = 1'b0;
        arm_req = 1'b0;
        kill    = 1'b0;
        cmd_vld = 1'b0;
        set_cmd(0);
        m_cnt = 0; m_mode = M_IDLE; m_arms = 0; m_wd = 0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_spd[i] = 0; end

        #22;
        chk("rst_spd",   spd_all(), 44'd0);
        chk("rst_tick",  frame_tick, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_fault", fault, 1'b0);
        rst_n = 1'b1;

        arm_req = 1'b1;
        run_frames(5);
        chk("armed_after_arming", armed, 1'b1);

        set_cmd(200);
        run_frames(7);
        chk("hold_200", spd_all(), {4{11'd200}});

        set_cmd(10);
        run_frames(7);
        chk("floor_64", spd_all(), {4{11'd64}});

        repeat (20) step();
        kill = 1'b1;
        step();
        chk("kill_fault", fault, 1'b1);
        chk("kill_zero", spd_all(), 44'd0);
        kill = 1'b0;
        repeat (FLEN + 6) step();
        chk("fault_sticky", fault, 1'b1);
        arm_req = 1'b0;
        step();
        chk("fault_exit", fault, 1'b0);

        arm_req = 1'b1;
        set_cmd(2040);
        run_frames(70);
        chk("at_2040", spd_all(), {4{11'd2040}});
        for (int k = 0; k < FLEN && m_cnt != FLEN - 1; k++) step();
        set_cmd(2047);
        cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("coincident_2047", spd_all(), {4{11'd2047}});

        repeat (10) step();
        arm_req = 1'b0;
        step();
        chk("drop_zero", spd_all(), 44'd0);
        chk("drop_disarm", armed, 1'b0);

`ifdef ESC_SEQ_CMD_WDOG_EN
        arm_req = 1'b1;
        run_frames(5);
        repeat (4 * FLEN) step();
        chk("wdog_fault", fault, 1'b1);
        arm_req = 1'b0;
        step();
`endif

        arm_req = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 299) == 0) arm_req = ~arm_req;
            kill    = ($urandom_range(0, 799) == 0);
            cmd_vld = ($urandom_range(0, 39) == 0);
            if (cmd_vld) for (int i = 0; i < 4; i++) cmd[i] = rand_cmd();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/esc_sequencer.md
Name: esc_sequencer

Overview:
- Sits between the flight controller and the four per-motor ESC PWM generators.
- Owns motor arming, kill/fault handling and slew-rate limiting of the four 11-bit speed commands.
- Output updates are aligned to the ESC PWM frame boundary: one new speed per PWM period. This boundary is when the 2^FRAME_W free-running counter reaches all ones.

Parameters:
- FRAME_W, 20: frame counter width; one frame = 2^FRAME_W clk cycles (must match the ESC PWM counter width).
- ARM_FRAMES, 16: number of frames that MIN_SPD is held before RUN.
- MIN_SPD, 11'd64: idle-spin speed during ARMING; floor on all outputs in RUN.
- SLEW_STEP, 11'd32: maximum change per output per frame in RUN.
- WDOG_FRAMES, 8: command watchdog limit in frames (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- arm_req  in  1  level; request that the motors be armed/run.
- kill  in  1  level; emergency stop, highest priority.
- cmd_vld  in  1  one-cycle strobe; the four cmd_* inputs are valid.
- frnt_cmd, bck_cmd, lft_cmd, rght_cmd  in  11 each  commanded speeds.
- frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  speeds driven to the ESC SPEED inputs.
- frame_tick  out  1  one-cycle pulse when the frame counter is all ones.
- armed  out  1  high in RUN only.
- fault  out  1  high in FAULT.

Behaviour:
- Interface: a single clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: frame counter 0, all *_spd 0, frame_tick 0, armed 0, fault 0, state IDLE, shadow registers 0, arm_cnt 0.
- Frame counter:
  - FRAME_W-bit free-running counter; wraps from all ones to 0.
  - frame_tick is combinational on (counter == all ones). The first tick occurs 2^FRAME_W-1 cycles after reset release.
- Shadow registers:
  - On cmd_vld, all four cmd_* inputs are captured into shadow registers.
  - If cmd_vld and frame_tick occur in the same cycle, the new command is used for that tick's update.
- Output registers:
  - Change only on a frame_tick cycle, except for the immediate zeroing below. New value is visible the cycle after the tick.
  - Zeroing on entering IDLE/FAULT takes effect the cycle after the transition condition, regardless of tick.
- States and transitions. Priority order: kill > arm_req drop > tick actions.
  - IDLE: outputs 0. arm_req & ~kill -> ARMING with arm_cnt = 0.
  - ARMING: on each tick, outputs = MIN_SPD and arm_cnt increments. On the tick where arm_cnt == ARM_FRAMES-1 -> RUN. ~arm_req -> IDLE.
  - RUN: on each tick, each output steps toward target = max(shadow, MIN_SPD):
    - if |target - out| <= SLEW_STEP then out = target;
    - else out = out ± SLEW_STEP.
    - ~arm_req -> IDLE.
  - FAULT: outputs 0, fault = 1. Exit to IDLE only when kill == 0 and arm_req == 0 in the same cycle.
  - kill == 1 in any state -> FAULT next cycle.
- Arithmetic:
  - Difference is computed as 12-bit signed.
  - Results are saturated to the range 0..2047; an output never wraps.
  - Targets above 2047 - SLEW_STEP converge exactly.
- Shadow values persist across IDLE; RUN always starts slewing from MIN_SPD.
- armed = (state == RUN). fault = (state == FAULT). Both are registered with the state.

Optional Feature:
- Macro: ESC_SEQ_CMD_WDOG_EN.
- Defined:
  - A frame-count watchdog is cleared by cmd_vld and incremented on each tick while in RUN.
  - Reaching WDOG_FRAMES -> FAULT, with the same exit rule as kill.
  - Watchdog is cleared on entry to RUN.
- Undefined: no watchdog; RUN holds the last shadow values indefinitely.

Decomposition:
- Package esc_seq_pkg:
  - state enum (IDLE, ARMING, RUN, FAULT);
  - speed width constant 11;
  - default MIN_SPD and SLEW_STEP.
- Sub-module esc_slew_lim: one per motor, four instances.
  - Inputs: cur, target, step.
  - Output: next, combinational, with saturation.
- The sequencer FSM, frame counter, shadow registers and watchdog stay in esc_sequencer.

Test Plan (FRAME_W=6, ARM_FRAMES=4, MIN_SPD=64, SLEW_STEP=32, WDOG_FRAMES=3):
- Reset, then arm_req=1 -> outputs 0 until the first tick; 64 for ticks 1..4; armed=1 after the 4th tick.
- RUN, cmd 200 on all motors -> outputs 96, 128, 160, 192, 200 on successive ticks, then hold 200.
- RUN at 200, cmd 10 -> outputs 168, 136, 104, 72, 64 (floor), then hold 64.
- kill mid-frame in RUN -> all outputs 0 and fault=1 the next cycle. Release kill with arm_req=1 -> stays FAULT. Drop arm_req -> IDLE.
- cmd_vld coincident with frame_tick (cmd 2047, out 2040) -> out 2047, no wrap. arm_req drop mid-frame -> outputs 0 the next cycle.
- With ESC_SEQ_CMD_WDOG_EN defined: RUN with no cmd_vld for 3 ticks -> FAULT after the 3rd tick. A cmd_vld every 2 frames -> stays in RUN.
